// File: rtl/mips_timer.sv
//------------------------------------------------------------------------------
// Module   : mips_timer
// Purpose  : Memory-mapped countdown timer (CTRL/PRESET/COUNT) with IRQ output.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_timer #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Addr,
  input  logic [31:0] WD,
  input  logic [3:0]  byteen,
  output logic [31:0] RD,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_q, irq_d;

  logic        sel;
  logic [1:0]  offset;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_preset;
  logic        unused_addr_lo;

  assign sel            = (Addr[31:4] == BASE[31:4]);
  assign offset         = Addr[3:2];
  assign wr             = sel && (byteen != 4'b0000);
  assign wr_ctrl        = wr && (offset == 2'd0);
  assign wr_preset      = wr && (offset == 2'd1);
  assign unused_addr_lo = ^Addr[1:0];

  always_comb begin
    RD = 32'h0;
    if (sel) begin
      case (offset)
        2'd0:    RD = {28'h0, ctrl_q};
        2'd1:    RD = preset_q;
        2'd2:    RD = count_q;
        default: RD = 32'h0;
      endcase
    end
  end

  // Both terms are flops, so the bus never reaches IRQ combinationally.
  assign IRQ = ctrl_q[3] & irq_q;

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    irq_d    = irq_q;

    if (wr) begin
      // A bus write freezes the FSM and COUNT for this cycle.
      if (wr_ctrl) begin
        irq_d = 1'b0;
        if (byteen[0]) begin
          ctrl_d = WD[3:0];
        end
      end
      if (wr_preset) begin
        for (int i = 0; i < 4; i++) begin
          if (byteen[i]) begin
            preset_d[8*i +: 8] = WD[8*i +: 8];
          end
        end
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (ctrl_q[0]) begin
            state_d = LOAD;
          end
        end
        LOAD: begin
          count_d = preset_q;
          state_d = CNT;
        end
        CNT: begin
          if (!ctrl_q[0]) begin
            state_d = IDLE;
          end else if (count_q > 32'd1) begin
            count_d = count_q - 32'd1;
          end else begin
            count_d = 32'h0;
            irq_d   = 1'b1;
            state_d = INT;
          end
        end
        INT: begin
          // Auto-reload leaves Enable set so IDLE immediately re-enters LOAD.
          if (ctrl_q[2:1] == 2'b01) begin
            irq_d = 1'b0;
          end else begin
            ctrl_d[0] = 1'b0;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ctrl_q   <= 4'h0;
      preset_q <= 32'h0;
      count_q  <= 32'h0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      irq_q    <= irq_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_timer.sv
//------------------------------------------------------------------------------
// Module   : tb_mips_timer
// Purpose  : Directed self-checking bench for mips_timer.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_timer;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_HOLE   = 32'h0000_7F0C;
  localparam logic [31:0] A_OTHER  = 32'h0000_7E04;

  logic        clk;
  logic        reset;
  logic [31:0] Addr;
  logic [31:0] WD;
  logic [3:0]  byteen;
  logic [31:0] RD;
  logic        IRQ;

  int n_checks;
  int n_pass;

  mips_timer #(.BASE(32'h0000_7F00)) dut (
    .clk    (clk),
    .reset  (reset),
    .Addr   (Addr),
    .WD     (WD),
    .byteen (byteen),
    .RD     (RD),
    .IRQ    (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Ends #1 after the write edge, with byteen released.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    Addr   = a;
    WD     = d;
    byteen = be;
    @(posedge clk);
    #1;
    byteen = 4'b0000;
    WD     = 32'h0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    byteen = 4'b0000;
    Addr   = a;
    #1;
    d = RD;
  endtask

  logic [31:0] rd;
  logic        exp_irq;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    reset    = 1'b0;
    Addr     = 32'h0;
    WD       = 32'h0;
    byteen   = 4'b0000;
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    step();

    // Reset state
    bus_read(A_CTRL, rd);   check("rst_ctrl", rd, 32'h0);
    bus_read(A_PRESET, rd); check("rst_preset", rd, 32'h0);
    bus_read(A_COUNT, rd);  check("rst_count", rd, 32'h0);
    check("rst_irq", {31'h0, IRQ}, 32'h0);

    // Byte-lane writes, ignored COUNT write, unmapped / unselected reads
    bus_write(A_PRESET, 32'hAABBCCDD, 4'b0001);
    bus_read(A_PRESET, rd); check("preset_lane0", rd, 32'h0000_00DD);
    bus_write(A_PRESET, 32'h11223344, 4'b0100);
    bus_read(A_PRESET, rd); check("preset_lane2", rd, 32'h0022_00DD);
    bus_write(A_COUNT, 32'h1234_5678, 4'b1111);
    bus_read(A_COUNT, rd);  check("count_wr_ignored", rd, 32'h0);
    bus_read(A_HOLE, rd);   check("hole_read", rd, 32'h0);
    bus_read(A_OTHER, rd);  check("unselected_read", rd, 32'h0);
    bus_write(A_CTRL, 32'hFFFF_FFF8, 4'b1111);
    bus_read(A_CTRL, rd);   check("ctrl_upper_zero", rd, 32'h8);

    // One-shot, PRESET=5, CTRL=0x9
    bus_write(A_PRESET, 32'd5, 4'b1111);
    bus_write(A_CTRL, 32'h9, 4'b1111);
    Addr = A_COUNT;
    step();
    bus_read(A_COUNT, rd); check("os_count_e1", rd, 32'h0);
    for (int k = 2; k <= 6; k++) begin
      step();
      bus_read(A_COUNT, rd); check("os_count", rd, 32'(7 - k));
      check("os_irq_low", {31'h0, IRQ}, 32'h0);
    end
    step();
    check("os_irq_e7", {31'h0, IRQ}, 32'h1);
    bus_read(A_COUNT, rd); check("os_count_e7", rd, 32'h0);
    step();
    bus_read(A_CTRL, rd); check("os_enable_cleared", rd, 32'h8);
    check("os_irq_e8", {31'h0, IRQ}, 32'h1);
    repeat (3) step();
    check("os_irq_held", {31'h0, IRQ}, 32'h1);
    bus_read(A_COUNT, rd); check("os_count_stays0", rd, 32'h0);
    bus_write(A_CTRL, 32'h8, 4'b1111);
    check("os_irq_cleared", {31'h0, IRQ}, 32'h0);

    // Auto-reload, PRESET=3, CTRL=0xB: pulses at E+5, E+11, E+17
    bus_write(A_PRESET, 32'd3, 4'b1111);
    bus_write(A_CTRL, 32'hB, 4'b1111);
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_irq = (k >= 5) && (((k - 5) % 6) == 0);
      check($sformatf("ar_irq_e%0d", k), {31'h0, IRQ}, {31'h0, exp_irq});
    end
    bus_write(A_CTRL, 32'h0, 4'b1111);
    repeat (4) step();
    check("ar_stopped_irq", {31'h0, IRQ}, 32'h0);

    // IM=0: internal flag sets but IRQ stays low
    bus_write(A_PRESET, 32'd2, 4'b1111);
    bus_write(A_CTRL, 32'h1, 4'b1111);
    for (int k = 1; k <= 6; k++) begin
      step();
      check("im0_irq_low", {31'h0, IRQ}, 32'h0);
    end
    check("im0_flag_set", {31'h0, dut.irq_q}, 32'h1);
    bus_read(A_CTRL, rd); check("im0_enable_cleared", rd, 32'h0);
    bus_write(A_CTRL, 32'h9, 4'b1111);
    check("im0_flag_cleared", {31'h0, dut.irq_q}, 32'h0);
    check("im0_irq_after_wr", {31'h0, IRQ}, 32'h0);
    bus_write(A_CTRL, 32'h0, 4'b1111);
    check("im0_irq_stop", {31'h0, IRQ}, 32'h0);

    // Asynchronous reset mid-count at COUNT=2
    bus_write(A_PRESET, 32'd4, 4'b1111);
    bus_write(A_CTRL, 32'h9, 4'b1111);
    repeat (4) step();
    bus_read(A_COUNT, rd); check("rstmid_count2", rd, 32'h2);
    reset = 1'b0;
    bus_read(A_CTRL, rd);   check("rstmid_ctrl", rd, 32'h0);
    bus_read(A_PRESET, rd); check("rstmid_preset", rd, 32'h0);
    bus_read(A_COUNT, rd);  check("rstmid_count", rd, 32'h0);
    check("rstmid_irq", {31'h0, IRQ}, 32'h0);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("rstmid_no_irq", {31'h0, IRQ}, 32'h0);
    end
    bus_read(A_COUNT, rd); check("rstmid_count_idle", rd, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mips_timer.md
MIPS_TIMER -- requirements
Module: mips_timer

Interface
REQ-001 SHALL have parameter BASE, default 32'h0000_7F00, meaning the 16-byte-aligned base address of the register window.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port Addr, input, 32 bits: the CPU data-bus byte address (the CPUAddr bus).
REQ-005 SHALL have port WD, input, 32 bits: the CPU write data (the CPUWD bus).
REQ-006 SHALL have port byteen, input, 4 bits: the CPU byte write enables (the CPUbyteen bus); nonzero means a write.
REQ-007 SHALL have port RD, output, 32 bits: read data returned to the CPU (into CPURD).
REQ-008 SHALL have port IRQ, output, 1 bit: interrupt request, wired to one HWInt bit.

Function
REQ-009 SHALL select itself when Addr[31:4]==BASE[31:4]; offset 0x0 is CTRL, 0x4 is PRESET, 0x8 is COUNT, 0xC is unmapped.
REQ-010 SHALL read combinationally: RD = the selected register; RD = 0 when unselected or at offset 0xC.
REQ-011 SHALL write CTRL/PRESET on the clock edge per byte lane: lane i is written iff byteen[i]; COUNT and 0xC writes are ignored.
REQ-012 SHALL define CTRL bits as: [0] Enable, [2:1] Mode, [3] IM (interrupt mask); CTRL[31:4] always reads 0.
REQ-013 SHALL treat Mode 2'b00 and 2'b10/2'b11 as one-shot, and Mode 2'b01 as auto-reload.
REQ-014 SHALL implement FSM states IDLE, LOAD, CNT and INT.
REQ-015 SHALL transition IDLE->LOAD when Enable=1; otherwise it stays in IDLE.
REQ-016 SHALL, in LOAD, set COUNT<=PRESET and go to CNT.
REQ-017 SHALL, in CNT: if Enable=0 go to IDLE with COUNT held; else if COUNT>1, COUNT<=COUNT-1; else COUNT<=0, irq_flag<=1, go to INT.
REQ-018 SHALL, in INT with one-shot mode: clear Enable and go to IDLE, with irq_flag held.
REQ-019 SHALL, in INT with auto-reload mode: clear irq_flag and go to IDLE, so the timer reloads via LOAD.
REQ-020 SHALL drive IRQ = IM & irq_flag, registered-only with no combinational path from the bus.
REQ-021 SHALL give a bus write cycle priority: the register updates, the FSM and COUNT hold for that cycle, and a CTRL write clears irq_flag.
REQ-022 SHALL, with PRESET=0 or 1, enter INT on the first CNT edge.
REQ-023 SHALL give timing from the CTRL write edge E that sets Enable with PRESET=P≥1: LOAD after E+1, CNT with COUNT=P after E+2, INT with IRQ=1 after E+P+2.
REQ-024 SHALL give an auto-reload period of P+3 cycles, with IRQ high for exactly 1 cycle per period.
REQ-025 SHALL never let COUNT wrap below 0.

Reset
REQ-026 SHALL, while reset=0, asynchronously set CTRL=0, PRESET=0, COUNT=0, irq_flag=0 and state=IDLE, so that IRQ=0 and RD reflects the zeroed registers.
REQ-027 SHALL, on reset assertion mid-count, abort immediately, and SHALL resume only on a new Enable write after release.

Verification
REQ-028 SHALL cover: after reset release, read 0x7F00/0x7F04/0x7F08 -> RD=0 each; IRQ=0.
REQ-029 SHALL cover: PRESET=5, CTRL=0x9 (one-shot, IM=1) at edge E -> COUNT 5,4,3,2,1 after E+2..E+6; IRQ=1 after E+7; Enable=0 after E+8; IRQ stays 1 until CTRL is written.
REQ-030 SHALL cover: PRESET=3, CTRL=0xB (auto-reload, IM=1) -> IRQ 1-cycle pulses every 6 cycles, first after E+5.
REQ-031 SHALL cover: PRESET write with byteen=4'b0001, WD=32'hAABBCCDD over PRESET=0 -> PRESET=32'h000000DD; a COUNT write is ignored.
REQ-032 SHALL cover: CTRL=0x1 (IM=0) run to INT -> IRQ stays 0 while the internal flag is set; then writing CTRL=0x9 -> flag cleared, IRQ stays 0.
REQ-033 SHALL cover: reset pulsed low at COUNT=2 in CNT -> all registers 0 and IDLE immediately, with no IRQ after release.
